// File: rtl/mem_stage_pkg.sv
// Shared types for the MIPS memory stage: access FSM states, EX/MEM control bundle
// and the debug view of the access engine.
package mem_stage_pkg;

  localparam int MEM_TO_W = 8;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } exmem_ctrl_t;

  typedef struct packed {
    mem_state_e            state;
    logic                  done;
    logic [MEM_TO_W-1:0]   count;
    logic                  mem_op_m;
  } mem_dbg_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
// Handshake: master raises req with we/addr/wdata and holds all four stable until the slave
// returns a one-cycle ack (rdata valid in that cycle); master drops req on the edge sampling ack.
interface mem_stage_if #(
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Data-memory access engine: issues one registered request per start, waits for ack or
// timeout, captures load data and flags completion.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                we_i,
  input  logic [DATA_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  mem_stage_if.master         dmem,
  output logic                busy_o,
  output logic                abort_o,
  output logic [DATA_W-1:0]   rdata_o,
  output mem_state_e          state_o,
  output logic                done_o,
  output logic [MEM_TO_W-1:0] count_o
);

  localparam logic [MEM_TO_W-1:0] TO_LAST = MEM_TO_W'(TIMEOUT - 1);

  mem_state_e          state_q, state_d;
  logic [MEM_TO_W-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    abort_o = 1'b0;
    if (state_q == MEM_IDLE) begin
      // Acks arriving while idle are stale and deliberately ignored.
      if (start_i) begin
        state_d = MEM_ACCESS;
        req_d   = 1'b1;
        we_d    = we_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        done_d  = 1'b0;
        count_d = '0;
      end
    end else begin
      if (dmem.ack) begin
        if (!we_q) rdata_d = dmem.rdata;
        req_d   = 1'b0;
        state_d = MEM_IDLE;
        done_d  = 1'b1;
      end else if (count_q == TO_LAST) begin
        abort_o = 1'b1;
        req_d   = 1'b0;
        state_d = MEM_IDLE;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + MEM_TO_W'(1);
      end
    end
  end

  assign busy_o     = (state_q == MEM_ACCESS);
  assign rdata_o    = rdata_q;
  assign state_o    = state_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM pipeline register, alignment check, stall/forward outputs,
// with the data-memory handshake delegated to mem_access_fsm.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [DATA_W-1:0] ALUOutput,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [4:0]        WriteRegE,
  input  logic              FlushM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic [4:0]        WriteRegM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic [DATA_W-1:0] ForwardMemVal,
  output logic              MemStall,
  output logic              MemFault,
  mem_stage_if.master       dmem,
  output mem_dbg_t          mem_dbg
);

  exmem_ctrl_t         ctrl_q, ctrl_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic                fault_q, fault_d;

  logic                stall;
  logic                abort;
  logic                mem_op_e;
  logic                aligned_e;
  logic                capture_op;
  logic                start;
  logic                misalign;
  mem_state_e          fsm_state;
  logic                fsm_done;
  logic [MEM_TO_W-1:0] fsm_count;

  assign mem_op_e   = MemtoRegE | MemWriteE;
  assign aligned_e  = is_word_aligned(ALUOutput[1:0]);
  // An op enters M only on a non-stalled, non-flushed edge; that same edge launches the access.
  assign capture_op = !stall && !FlushM && mem_op_e;
  assign start      = capture_op && aligned_e;
  assign misalign   = capture_op && !aligned_e;

  mem_access_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_access (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .we_i    (MemWriteE),
    .addr_i  (ALUOutput),
    .wdata_i (WriteDataE),
    .dmem    (dmem),
    .busy_o  (stall),
    .abort_o (abort),
    .rdata_o (ReadDataM),
    .state_o (fsm_state),
    .done_o  (fsm_done),
    .count_o (fsm_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      wreg_q  <= '0;
      alu_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      wreg_q  <= wreg_d;
      alu_q   <= alu_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    wreg_d = wreg_q;
    alu_d  = alu_q;
    if (!stall) begin
      if (FlushM) begin
        ctrl_d = '0;
        wreg_d = '0;
        alu_d  = '0;
      end else begin
        ctrl_d = '{reg_write: RegWriteE, mem_to_reg: MemtoRegE, mem_write: MemWriteE};
        if (mem_op_e && !aligned_e) ctrl_d = '0;
        wreg_d = WriteRegE;
        alu_d  = ALUOutput;
      end
    end else if (abort) begin
      // A timed-out access must not write garbage into the register file.
      ctrl_d.reg_write = 1'b0;
    end
  end

  assign fault_d = fault_q | misalign | abort;

  assign RegWriteM     = ctrl_q.reg_write;
  assign MemtoRegM     = ctrl_q.mem_to_reg;
  assign WriteRegM     = wreg_q;
  assign ALUOutM       = alu_q;
  assign ForwardMemVal = alu_q;
  assign MemStall      = stall;
  assign MemFault      = fault_q;
  assign mem_dbg       = '{state: fsm_state, done: fsm_done, count: fsm_count,
                           mem_op_m: ctrl_q.mem_to_reg | ctrl_q.mem_write};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: DUT A (TIMEOUT=8) covers the pipeline/memory scenarios, DUT B
// (TIMEOUT=3) covers the ack-timeout abort.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic rst_n;

  logic        rw_a, mtr_a, mw_a, flush_a;
  logic [31:0] alu_a, wd_a;
  logic [4:0]  wr_a;
  logic        rwm_a, mtrm_a, stall_a, fault_a;
  logic [4:0]  wrm_a;
  logic [31:0] aluo_a, rd_a, fwd_a;
  mem_dbg_t    dbg_a;

  logic        rw_b, mtr_b, mw_b, flush_b;
  logic [31:0] alu_b, wd_b;
  logic [4:0]  wr_b;
  logic        rwm_b, mtrm_b, stall_b, fault_b;
  logic [4:0]  wrm_b;
  logic [31:0] aluo_b, rd_b, fwd_b;
  mem_dbg_t    dbg_b;

  mem_stage_if #(.DATA_W(32)) dmem_a ();
  mem_stage_if #(.DATA_W(32)) dmem_b ();

  logic [31:0] exp_q[$];
  int n_checks;
  int n_fail;

  mem_stage #(.DATA_W(32), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(rw_a), .MemtoRegE(mtr_a), .MemWriteE(mw_a),
    .ALUOutput(alu_a), .WriteDataE(wd_a), .WriteRegE(wr_a), .FlushM(flush_a),
    .RegWriteM(rwm_a), .MemtoRegM(mtrm_a), .WriteRegM(wrm_a), .ALUOutM(aluo_a),
    .ReadDataM(rd_a), .ForwardMemVal(fwd_a), .MemStall(stall_a), .MemFault(fault_a),
    .dmem(dmem_a), .mem_dbg(dbg_a)
  );

  mem_stage #(.DATA_W(32), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(rw_b), .MemtoRegE(mtr_b), .MemWriteE(mw_b),
    .ALUOutput(alu_b), .WriteDataE(wd_b), .WriteRegE(wr_b), .FlushM(flush_b),
    .RegWriteM(rwm_b), .MemtoRegM(mtrm_b), .WriteRegM(wrm_b), .ALUOutM(aluo_b),
    .ReadDataM(rd_b), .ForwardMemVal(fwd_b), .MemStall(stall_b), .MemFault(fault_b),
    .dmem(dmem_b), .mem_dbg(dbg_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input bit b, input logic rw, input logic mtr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    if (b) begin
      rw_b = rw; mtr_b = mtr; mw_b = mw; alu_b = alu; wd_b = wd; wr_b = wr;
    end else begin
      rw_a = rw; mtr_a = mtr; mw_a = mw; alu_a = alu; wd_a = wd; wr_a = wr;
    end
  endtask

  // Memory responder: ack in the ack_lat-th stalled cycle (0 = never); bounded at 40 cycles.
  task automatic run_access(input bit b, input int ack_lat, input logic [31:0] rdata,
                            output int stall_n, output int req_n, output bit stable);
    logic [31:0] a0, w0;
    logic        we0;
    a0 = b ? dmem_b.addr : dmem_a.addr;
    w0 = b ? dmem_b.wdata : dmem_a.wdata;
    we0 = b ? dmem_b.we : dmem_a.we;
    stall_n = 0;
    req_n = 0;
    stable = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (!(b ? stall_b : stall_a)) break;
      stall_n++;
      if (b ? dmem_b.req : dmem_a.req) req_n++;
      if ((b ? dmem_b.addr : dmem_a.addr) !== a0 || (b ? dmem_b.wdata : dmem_a.wdata) !== w0 ||
          (b ? dmem_b.we : dmem_a.we) !== we0) stable = 1'b0;
      if (cyc == ack_lat) begin
        if (b) begin dmem_b.ack = 1'b1; dmem_b.rdata = rdata; end
        else begin dmem_a.ack = 1'b1; dmem_a.rdata = rdata; end
      end
      tick();
      dmem_a.ack = 1'b0;
      dmem_b.ack = 1'b0;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    drive_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    drive_op(1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    flush_a = 1'b0; flush_b = 1'b0;
    dmem_a.ack = 1'b0; dmem_a.rdata = 32'h0;
    dmem_b.ack = 1'b0; dmem_b.rdata = 32'h0;
    repeat (2) tick();
    n_checks++; if ({rwm_a, mtrm_a, wrm_a} !== 7'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", {rwm_a, mtrm_a, wrm_a}); end
    n_checks++; if (aluo_a !== 32'h0 || rd_a !== 32'h0 || fwd_a !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", aluo_a, rd_a, fwd_a); end
    n_checks++; if ({stall_a, fault_a, dmem_a.req} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {stall_a, fault_a, dmem_a.req}); end
    n_checks++; if (dbg_a.state !== MEM_IDLE || dbg_a.done !== 1'b0 || dbg_a.count !== 8'h0) begin n_fail++; $display("FAIL reset_fsm: got %h want 0", dbg_a); end
    n_checks++; if ({dmem_b.req, fault_b, stall_b} !== 3'b000) begin n_fail++; $display("FAIL reset_b: got %b want 000", {dmem_b.req, fault_b, stall_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [31:0] v;
    logic [4:0]  r;
    drive_op(0, 1, 0, 0, 32'h5, 32'h0, 5'd8);
    exp_q.push_back(32'h5);
    tick();
    n_checks++; if (rwm_a !== 1'b1 || wrm_a !== 5'd8) begin n_fail++; $display("FAIL alu_ctrl: got rw=%b wr=%0d want rw=1 wr=8", rwm_a, wrm_a); end
    n_checks++; if (aluo_a !== exp_q.pop_front()) begin n_fail++; $display("FAIL alu_result: got %h want 5", aluo_a); end
    n_checks++; if (fwd_a !== 32'h5 || stall_a !== 1'b0 || dmem_a.req !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_stall: got fwd=%h stall=%b req=%b want 5/0/0", fwd_a, stall_a, dmem_a.req); end
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      r = 5'($urandom_range(1, 31));
      drive_op(0, 1, 0, 0, v, 32'($urandom), r);
      exp_q.push_back(v);
      tick();
      n_checks++; if (fwd_a !== exp_q.pop_front() || wrm_a !== r || stall_a !== 1'b0) begin n_fail++; $display("FAIL alu_rand%0d: got fwd=%h wr=%0d stall=%b want %h/%0d/0", i, fwd_a, wrm_a, stall_a, v, r); end
    end
  endtask

  task automatic test_load();
    int sn, rn;
    bit st;
    drive_op(0, 1, 1, 0, 32'h100, 32'h0, 5'd3);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    n_checks++; if (dmem_a.req !== 1'b1 || dmem_a.we !== 1'b0 || dmem_a.addr !== 32'h100) begin n_fail++; $display("FAIL load_req: got req=%b we=%b addr=%h want 1/0/100", dmem_a.req, dmem_a.we, dmem_a.addr); end
    n_checks++; if (stall_a !== 1'b1 || dbg_a.state !== MEM_ACCESS) begin n_fail++; $display("FAIL load_stall: got stall=%b state=%b want 1/ACCESS", stall_a, dbg_a.state); end
    drive_op(0, 1, 0, 0, 32'h77, 32'h0, 5'd9);
    run_access(0, 1, 32'hDEADBEEF, sn, rn, st);
    n_checks++; if (sn !== 1 || rn !== 1) begin n_fail++; $display("FAIL load_latency: got stall=%0d req=%0d want 1/1", sn, rn); end
    n_checks++; if (rd_a !== exp_q.pop_front()) begin n_fail++; $display("FAIL load_data: got %h want deadbeef", rd_a); end
    n_checks++; if (dmem_a.req !== 1'b0 || wrm_a !== 5'd3 || mtrm_a !== 1'b1) begin n_fail++; $display("FAIL load_hold: got req=%b wr=%0d mtr=%b want 0/3/1", dmem_a.req, wrm_a, mtrm_a); end
    dmem_a.ack = 1'b1;
    dmem_a.rdata = 32'hBAD0BAD0;
    tick();
    dmem_a.ack = 1'b0;
    n_checks++; if (wrm_a !== 5'd9 || rd_a !== 32'hDEADBEEF || dmem_a.req !== 1'b0) begin n_fail++; $display("FAIL load_after: got wr=%0d rd=%h req=%b want 9/deadbeef/0", wrm_a, rd_a, dmem_a.req); end
  endtask

  task automatic test_store();
    int sn, rn;
    bit st;
    drive_op(0, 0, 0, 1, 32'h104, 32'h1234, 5'd0);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h1234);
    tick();
    n_checks++; if (dmem_a.req !== 1'b1 || dmem_a.we !== 1'b1 || dmem_a.addr !== exp_q.pop_front()) begin n_fail++; $display("FAIL store_req: got req=%b we=%b addr=%h want 1/1/104", dmem_a.req, dmem_a.we, dmem_a.addr); end
    n_checks++; if (dmem_a.wdata !== exp_q.pop_front()) begin n_fail++; $display("FAIL store_wdata: got %h want 1234", dmem_a.wdata); end
    drive_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    run_access(0, 4, 32'($urandom), sn, rn, st);
    n_checks++; if (sn !== 4 || rn !== 4 || st !== 1'b1) begin n_fail++; $display("FAIL store_latency: got stall=%0d req=%0d stable=%b want 4/4/1", sn, rn, st); end
    n_checks++; if (rd_a !== 32'hDEADBEEF || fault_a !== 1'b0) begin n_fail++; $display("FAIL store_rdata: got rd=%h fault=%b want deadbeef/0", rd_a, fault_a); end
  endtask

  task automatic test_back_to_back();
    int sn, rn;
    bit st;
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    drive_op(0, 1, 1, 0, 32'h200, 32'h0, 5'd10);
    exp_q.push_back(r1);
    tick();
    drive_op(0, 1, 1, 0, 32'h204, 32'h0, 5'd11);
    exp_q.push_back(r2);
    run_access(0, 1, r1, sn, rn, st);
    n_checks++; if (sn !== 1 || rd_a !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_first: got stall=%0d rd=%h want 1/%h", sn, rd_a, r1); end
    tick();
    n_checks++; if (dmem_a.req !== 1'b1 || dmem_a.addr !== 32'h204 || wrm_a !== 5'd11) begin n_fail++; $display("FAIL b2b_second_req: got req=%b addr=%h wr=%0d want 1/204/11", dmem_a.req, dmem_a.addr, wrm_a); end
    drive_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    run_access(0, 2, r2, sn, rn, st);
    n_checks++; if (sn !== 2 || rd_a !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_second: got stall=%0d rd=%h want 2/%h", sn, rd_a, r2); end
  endtask

  task automatic test_flush_stall();
    int sn, rn;
    bit st;
    logic [31:0] r;
    r = $urandom;
    drive_op(0, 1, 1, 0, 32'h400, 32'h0, 5'd6);
    tick();
    flush_a = 1'b1;
    drive_op(0, 1, 0, 0, 32'h999, 32'h0, 5'd12);
    tick();
    n_checks++; if (wrm_a !== 5'd6 || aluo_a !== 32'h400 || mtrm_a !== 1'b1 || stall_a !== 1'b1) begin n_fail++; $display("FAIL flush_in_stall: got wr=%0d alu=%h mtr=%b stall=%b want 6/400/1/1", wrm_a, aluo_a, mtrm_a, stall_a); end
    exp_q.push_back(r);
    run_access(0, 1, r, sn, rn, st);
    n_checks++; if (rd_a !== exp_q.pop_front()) begin n_fail++; $display("FAIL flush_load_data: got %h want %h", rd_a, r); end
    tick();
    n_checks++; if (rwm_a !== 1'b0 || wrm_a !== 5'd0 || aluo_a !== 32'h0) begin n_fail++; $display("FAIL flush_bubble: got rw=%b wr=%0d alu=%h want 0/0/0", rwm_a, wrm_a, aluo_a); end
    flush_a = 1'b0;
  endtask

  task automatic test_misaligned();
    drive_op(0, 1, 1, 0, 32'h102, 32'h0, 5'd4);
    tick();
    n_checks++; if (dmem_a.req !== 1'b0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL misalign_noreq: got req=%b stall=%b want 0/0", dmem_a.req, stall_a); end
    n_checks++; if (fault_a !== 1'b1 || rwm_a !== 1'b0 || mtrm_a !== 1'b0) begin n_fail++; $display("FAIL misalign_squash: got fault=%b rw=%b mtr=%b want 1/0/0", fault_a, rwm_a, mtrm_a); end
    drive_op(0, 1, 0, 0, 32'h3, 32'h0, 5'd2);
    tick();
    n_checks++; if (fault_a !== 1'b1 || dmem_a.req !== 1'b0 || rwm_a !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got fault=%b req=%b rw=%b want 1/0/1", fault_a, dmem_a.req, rwm_a); end
  endtask

  task automatic test_timeout();
    int sn, rn;
    bit st;
    n_checks++; if (fault_b !== 1'b0) begin n_fail++; $display("FAIL timeout_prefault: got %b want 0", fault_b); end
    drive_op(1, 1, 1, 0, 32'h300, 32'h0, 5'd5);
    tick();
    n_checks++; if (dmem_b.req !== 1'b1 || stall_b !== 1'b1) begin n_fail++; $display("FAIL timeout_req: got req=%b stall=%b want 1/1", dmem_b.req, stall_b); end
    drive_op(1, 1, 0, 0, 32'h55, 32'h0, 5'd7);
    exp_q.push_back(32'h55);
    run_access(1, 0, 32'h0, sn, rn, st);
    n_checks++; if (sn !== 3 || rn !== 3) begin n_fail++; $display("FAIL timeout_len: got stall=%0d req=%0d want 3/3", sn, rn); end
    n_checks++; if (dmem_b.req !== 1'b0 || fault_b !== 1'b1 || rwm_b !== 1'b0 || stall_b !== 1'b0) begin n_fail++; $display("FAIL timeout_abort: got req=%b fault=%b rw=%b stall=%b want 0/1/0/0", dmem_b.req, fault_b, rwm_b, stall_b); end
    tick();
    n_checks++; if (wrm_b !== 5'd7 || rwm_b !== 1'b1 || aluo_b !== exp_q.pop_front()) begin n_fail++; $display("FAIL timeout_resume: got wr=%0d rw=%b alu=%h want 7/1/55", wrm_b, rwm_b, aluo_b); end
  endtask

  task automatic test_reset_mid_access();
    drive_op(0, 1, 1, 0, 32'h500, 32'h0, 5'd13);
    tick();
    n_checks++; if (dmem_a.req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got req=%b want 1", dmem_a.req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dmem_a.req !== 1'b0 || stall_a !== 1'b0 || fault_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got req=%b stall=%b fault=%b want 0/0/0", dmem_a.req, stall_a, fault_a); end
    n_checks++; if ({rwm_a, mtrm_a, wrm_a} !== 7'h0 || aluo_a !== 32'h0 || rd_a !== 32'h0) begin n_fail++; $display("FAIL rst_mid_outs: got ctrl=%h alu=%h rd=%h want 0", {rwm_a, mtrm_a, wrm_a}, aluo_a, rd_a); end
    drive_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (dmem_a.req !== 1'b0 || dbg_a.state !== MEM_IDLE) begin n_fail++; $display("FAIL rst_mid_after: got req=%b state=%b want 0/IDLE", dmem_a.req, dbg_a.state); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_flush_stall();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
